// File: rtl/flp_pkg.sv
// Shared FP32 field widths, bias, special-value constants and the round-to-nearest-even
// increment rule, shared by the round/pack stages.
package flp_pkg;

    localparam int FP32_EW   = 8;
    localparam int FP32_SW   = 23;
    localparam int FP32_BIAS = 127;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

    // Round up on guard, unless it is an exact tie and the kept LSB is already even.
    function automatic logic rne_inc(input logic lsb, input logic g, input logic s);
        return g & (s | lsb);
    endfunction

endpackage

// File: rtl/flp_rne_inc.sv
// Round-to-nearest-even increment and inexact detection.
// The input is the kept LSB followed by the RSWIDTH rounding bits.
module flp_rne_inc
    import flp_pkg::*;
#(
    parameter int RSWIDTH = 2
) (
    input  logic [RSWIDTH:0] i_bits,
    output logic             o_inc,
    output logic             o_nx
);

    logic w_g;
    logic w_s;

    assign w_g   = i_bits[RSWIDTH-1];
    assign w_s   = |i_bits[RSWIDTH-2:0];
    assign o_inc = rne_inc(i_bits[RSWIDTH], w_g, w_s);
    assign o_nx  = w_g | w_s;

endmodule

// File: rtl/flp_rndpack.sv
// FP32 round-and-pack: stage 1 forms the final exponent and the rounding decision,
// stage 2 applies the increment, renormalises on carry, resolves specials and packs.
module flp_rndpack
    import flp_pkg::*;
#(
    parameter int EWIDTH  = FP32_EW,
    parameter int SWIDTH  = FP32_SW,
    parameter int RSWIDTH = 2,
    parameter int EDWIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_sign,
    input  logic [EWIDTH+1:0]         i_exp,
    input  logic [EDWIDTH-1:0]        i_exd,
    input  logic [SWIDTH+RSWIDTH:0]   i_sg,
    input  logic                      i_nan,
    input  logic                      i_inf,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [EWIDTH+SWIDTH:0]    o_res,
    output logic                      o_of,
    output logic                      o_uf,
    output logic                      o_nx
);

    localparam int EW3 = EWIDTH + 3;
    localparam logic signed [EW3-1:0] E_MAX = EW3'((1 << EWIDTH) - 1);

    logic w_en1;
    logic w_en2;
    logic w_inc1;
    logic w_nx1;
    logic signed [EW3-1:0] w_exp_ext;
    logic signed [EW3-1:0] w_exd_ext;
    logic signed [EW3-1:0] w_e1;

    logic                  r_v1;
    logic                  r_sign1;
    logic signed [EW3-1:0] r_e1;
    logic [SWIDTH:0]       r_sig1;
    logic                  r_inc1;
    logic                  r_nx1;
    logic                  r_nan1;
    logic                  r_inf1;

    logic                  r_v2;
    logic [EWIDTH+SWIDTH:0] r_res;
    logic                  r_of;
    logic                  r_uf;
    logic                  r_nx;

    logic [SWIDTH+1:0]     w_m;
    logic                  w_carry;
    logic [SWIDTH-1:0]     w_frac;
    logic signed [EW3-1:0] w_e2;
    logic [EWIDTH+SWIDTH:0] w_res_next;
    logic                  w_of_next;
    logic                  w_uf_next;
    logic                  w_nx_next;

    assign w_en2   = ~r_v2 | i_ready;
    assign w_en1   = ~r_v1 | w_en2;
    assign o_ready = w_en1;
    assign o_valid = r_v2;
    assign o_res   = r_res;
    assign o_of    = r_of;
    assign o_uf    = r_uf;
    assign o_nx    = r_nx;

    // Widened so that any signed exponent plus any delta is representable without wrap.
    assign w_exp_ext = EW3'($signed(i_exp));
    assign w_exd_ext = EW3'($signed(i_exd));
    assign w_e1      = w_exp_ext + w_exd_ext;

    flp_rne_inc #(
        .RSWIDTH (RSWIDTH)
    ) u_rne (
        .i_bits (i_sg[RSWIDTH:0]),
        .o_inc  (w_inc1),
        .o_nx   (w_nx1)
    );

    assign w_m     = {1'b0, r_sig1} + {{(SWIDTH+1){1'b0}}, r_inc1};
    assign w_carry = w_m[SWIDTH+1];
    assign w_frac  = w_carry ? w_m[SWIDTH:1] : w_m[SWIDTH-1:0];
    assign w_e2    = r_e1 + {{(EW3-1){1'b0}}, w_carry};

    always_comb begin
        w_res_next = {r_sign1, w_e2[EWIDTH-1:0], w_frac};
        w_of_next  = 1'b0;
        w_uf_next  = 1'b0;
        w_nx_next  = r_nx1;
        if (r_nan1) begin
            w_res_next = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(SWIDTH-1){1'b0}}};
            w_nx_next  = 1'b0;
        end else if (r_inf1) begin
            w_res_next = {r_sign1, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
            w_nx_next  = 1'b0;
        end else if (!r_sig1[SWIDTH]) begin
            w_res_next = {r_sign1, {(EWIDTH+SWIDTH){1'b0}}};
            w_nx_next  = 1'b0;
        end else if (w_e2 >= E_MAX) begin
            w_res_next = {r_sign1, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
            w_of_next  = 1'b1;
            w_nx_next  = 1'b1;
        end else if (w_e2[EW3-1] || (w_e2 == '0)) begin
            w_res_next = {r_sign1, {(EWIDTH+SWIDTH){1'b0}}};
            w_uf_next  = 1'b1;
            w_nx_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_res <= '0;
            r_of  <= 1'b0;
            r_uf  <= 1'b0;
            r_nx  <= 1'b0;
        end else begin
            if (w_en1) begin
                r_v1 <= i_valid;
                if (i_valid) begin
                    r_sign1 <= i_sign;
                    r_e1    <= w_e1;
                    r_sig1  <= i_sg[SWIDTH+RSWIDTH:RSWIDTH];
                    r_inc1  <= w_inc1;
                    r_nx1   <= w_nx1;
                    r_nan1  <= i_nan;
                    r_inf1  <= i_inf;
                end
            end
            // Output registers only move when the downstream slot is free, so a stall holds them.
            if (w_en2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_res <= w_res_next;
                    r_of  <= w_of_next;
                    r_uf  <= w_uf_next;
                    r_nx  <= w_nx_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_flp_rndpack.sv
// Directed vector table plus backpressure and reset sequences for flp_rndpack.
module tb_flp_rndpack;
    import flp_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [9:0]  i_exp;
    logic [9:0]  i_exd;
    logic [25:0] i_sg;
    logic        i_nan;
    logic        i_inf;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_res;
    logic        o_of;
    logic        o_uf;
    logic        o_nx;

    flp_rndpack dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sign  (i_sign),
        .i_exp   (i_exp),
        .i_exd   (i_exd),
        .i_sg    (i_sg),
        .i_nan   (i_nan),
        .i_inf   (i_inf),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_of    (o_of),
        .o_uf    (o_uf),
        .o_nx    (o_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [9:0]  exd;
        logic [25:0] sg;
        logic        nan;
        logic        inf;
        logic [31:0] res;
        logic        of;
        logic        uf;
        logic        nx;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   cyc;
        v = vecs[idx];
        chk($sformatf("v%0d_ready", idx), {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1;
        i_sign  = v.sign;
        i_exp   = v.exp;
        i_exd   = v.exd;
        i_sg    = v.sg;
        i_nan   = v.nan;
        i_inf   = v.inf;
        tick();
        i_valid = 1'b0;
        cyc = 1;
        while (!o_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk($sformatf("v%0d_valid", idx), {31'd0, o_valid}, 32'd1);
        chk($sformatf("v%0d_latency", idx), cyc, 32'd2);
        chk($sformatf("v%0d_res", idx), o_res, v.res);
        chk($sformatf("v%0d_flags", idx), {29'd0, o_of, o_uf, o_nx}, {29'd0, v.of, v.uf, v.nx});
        $display("vec %0d: res=0x%08h of=%0b uf=%0b nx=%0b", idx, o_res, o_of, o_uf, o_nx);
        tick();
    endtask

    initial begin
        int sent;
        int got;
        int cyc;

        //          sign exp      exd      sg              nan  inf  res            of   uf   nx
        vecs[0]  = '{1'b0, 10'd127, 10'd0,   26'h2000000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 10'd127, 10'd0,   26'h2000002, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 10'd127, 10'd0,   26'h2000006, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 10'd127, 10'd0,   26'h3FFFFFF, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 10'd127, 10'h3FE, 26'h3FFFFFF, 1'b0, 1'b0, 32'h3F000000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 10'd254, 10'd0,   26'h3FFFFFF, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 10'd1,   10'h3FF, 26'h2000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 10'd127, 10'd0,   26'h2000000, 1'b1, 1'b0, FP32_QNAN,    1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 10'd127, 10'd0,   26'h2000000, 1'b0, 1'b1, FP32_PINF | 32'h80000000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 10'd300, 10'd0,   26'h0000003, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 10'd130, 10'd0,   26'h2000001, 1'b0, 1'b0, 32'hC1000000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 10'd254, 10'd0,   26'h3FFFFFC, 1'b0, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 10'd255, 10'd0,   26'h2000000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 10'h3FB, 10'd6,   26'h2000000, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 10'd127, 10'd0,   26'h2000000, 1'b1, 1'b1, FP32_QNAN,    1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 10'd100, 10'd200, 26'h2000000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 10'd10,  10'h3EC, 26'h2000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 10'd127, 10'd0,   26'h2000005, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 10'd1,   10'd0,   26'h2000000, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_sign = 1'b0;
        i_exp = '0; i_exd = '0; i_sg = '0; i_nan = 1'b0; i_inf = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_res", o_res, 32'd0);
        chk("rst_flags", {29'd0, o_of, o_uf, o_nx}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", {31'd0, o_ready}, 32'd1);

        for (int k = 0; k < NVEC; k++) run_vec(k);

        // Backpressure: six back-to-back operands, downstream stalls on cycles 2..4.
        sent = 0; got = 0; cyc = 0;
        while (got < 6 && cyc < 40) begin
            i_ready = !(cyc >= 2 && cyc <= 4);
            i_valid = (sent < 6);
            i_sign  = 1'b0;
            i_exp   = 10'(FP32_BIAS);
            i_exd   = '0;
            i_sg    = 26'h2000000 + (26'(sent) << 2);
            i_nan   = 1'b0;
            i_inf   = 1'b0;
            #1;
            if (sent < 6)
                chk($sformatf("bp_ready_c%0d", cyc), {31'd0, o_ready}, {31'd0, !(cyc >= 2 && cyc <= 4)});
            if (cyc >= 2)
                chk($sformatf("bp_valid_c%0d", cyc), {31'd0, o_valid}, 32'd1);
            if (o_valid)
                chk($sformatf("bp_res_c%0d", cyc), o_res, 32'h3F800000 + 32'(got));
            if (o_valid && i_ready) begin
                $display("bp out %0d: res=0x%08h cycle=%0d", got, o_res, cyc);
                got++;
            end
            if (i_valid && o_ready) sent++;
            cyc++;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("bp_count", got, 32'd6);
        chk("bp_cycles", cyc, 32'd11);
        tick();
        chk("bp_drained", {31'd0, o_valid}, 32'd0);

        // Reset with two operands in flight.
        i_valid = 1'b1; i_exp = 10'd127; i_exd = '0; i_sg = 26'h2000000;
        tick();
        tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_res", o_res, 32'd0);
        rst = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("post_rst_valid_%0d", k), {31'd0, o_valid}, 32'd0);
        end
        $display("reset sequence: o_valid=%0b o_res=0x%08h", o_valid, o_res);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
